awg_sequencer: RTL and testbench

- Host-side controller for the arbitrary pattern generator (APG) in the axi_clk domain.
- Streams a pattern of num_samples words into the APG write buffer, fires a run pulse, and tracks the APG status through its transaction.
- Reads the captured input samples back out as a stream, then repeats for num_loops iterations.
- Replaces per-word software register pokes; reports completion, loop progress and errors.

---
 rtl/awg_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_awg_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_sequencer.sv
// awg_sequencer: streams a pattern into the APG, runs it, and streams the captured samples back per loop
module awg_sequencer #(
  parameter int NUM_SIG     = 8,
  parameter int NUM_SAMP    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic               axi_clk,
  input  logic               axi_resetn,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [31:0]        num_samples_i,
  input  logic [15:0]        num_loops_i,
  input  logic [31:0]        timeout_cycles_i,
  input  logic               pat_valid_i,
  output logic               pat_ready_o,
  input  logic [NUM_SIG-1:0] pat_data_i,
  output logic               cap_valid_o,
  input  logic               cap_ready_i,
  output logic [NUM_SIG-1:0] cap_data_o,
  output logic               cap_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         err_code_o,
  output logic [15:0]        loop_idx_o,
  output logic               awg_run_o,
  output logic [NUM_SIG-1:0] awg_write_channel_o,
  output logic               awg_wr_strobe_o,
  output logic               awg_rd_strobe_o,
  input  logic [NUM_SIG-1:0] awg_read_channel_i,
  input  logic [2:0]         awg_status_i,
  input  logic [31:0]        awg_write_buffer_len_i
);
  typedef enum logic [3:0] {IDLE, WAIT_IDLE_PRE, LOAD, CHECK, FIRE, WAIT_TRIG, WAIT_DONE, READ, DRAIN} state_t;
  state_t state_q;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [31:0] ns_q, to_q, cnt_q, tcnt_q, tcnt_d;
  logic [15:0] nl_q, loop_q;
  logic [1:0] ph_q, err_q;
  logic [NUM_SIG-1:0] cap_data_q, wch_q;
  logic pat_ready_q, cap_valid_q, cap_last_q, done_q, run_q, wrs_q, rds_q;
  logic [2:0] ss;
  logic to_hit, last_rd, last_loop;
  assign ss = sync_q[SYNC_STAGES-1];
  assign tcnt_d = tcnt_q + 32'd1;
  assign to_hit = (to_q != 32'd0) && (tcnt_d == to_q);
  assign last_rd = (cnt_q + 32'd1) == ns_q;
  assign last_loop = (loop_q + 16'd1) == nl_q;
  assign pat_ready_o = pat_ready_q;
  assign cap_valid_o = cap_valid_q;
  assign cap_data_o = cap_data_q;
  assign cap_last_o = cap_last_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_code_o = err_q;
  assign loop_idx_o = loop_q;
  assign awg_run_o = run_q;
  assign awg_write_channel_o = wch_q;
  assign awg_wr_strobe_o = wrs_q;
  assign awg_rd_strobe_o = rds_q;
  // bring the wave_clk-domain APG status into axi_clk
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'd0;
    end else begin
      sync_q[0] <= awg_status_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // sequencer FSM; strobes and done are single-cycle pulses cleared by default each cycle
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      state_q <= IDLE;
      ns_q <= '0;
      nl_q <= '0;
      to_q <= '0;
      cnt_q <= '0;
      tcnt_q <= '0;
      ph_q <= '0;
      err_q <= '0;
      loop_q <= '0;
      cap_data_q <= '0;
      wch_q <= '0;
      pat_ready_q <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_last_q <= 1'b0;
      done_q <= 1'b0;
      run_q <= 1'b0;
      wrs_q <= 1'b0;
      rds_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      run_q <= 1'b0;
      wrs_q <= 1'b0;
      rds_q <= 1'b0;
      if (abort_i && state_q != IDLE) begin
        err_q <= 2'd3;
        pat_ready_q <= 1'b0;
        cap_valid_q <= 1'b0;
        cap_last_q <= 1'b0;
        tcnt_q <= '0;
        state_q <= (state_q inside {FIRE, WAIT_TRIG, WAIT_DONE}) ? DRAIN : IDLE;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            ns_q <= num_samples_i;
            nl_q <= (num_loops_i == 16'd0) ? 16'd1 : num_loops_i;
            to_q <= timeout_cycles_i;
            if (num_samples_i == 32'd0 || num_samples_i > 32'(NUM_SAMP)) err_q <= 2'd1;
            else begin
              err_q <= 2'd0;
              loop_q <= '0;
              state_q <= WAIT_IDLE_PRE;
            end
          end
          WAIT_IDLE_PRE: if (ss == 3'b000) begin
            cnt_q <= '0;
            pat_ready_q <= 1'b1;
            state_q <= LOAD;
          end
          LOAD: if (wrs_q) begin
            pat_ready_q <= cnt_q != ns_q;
            if (cnt_q == ns_q) state_q <= CHECK;
          end else if (pat_valid_i && pat_ready_q) begin
            wch_q <= pat_data_i;
            wrs_q <= 1'b1;
            pat_ready_q <= 1'b0;
            cnt_q <= cnt_q + 32'd1;
          end
          CHECK: if (awg_write_buffer_len_i != ns_q) begin
            err_q <= 2'd1;
            state_q <= IDLE;
          end else begin
            run_q <= 1'b1;
            state_q <= FIRE;
          end
          FIRE: state_q <= WAIT_TRIG;
          WAIT_TRIG: if (ss[2]) begin
            tcnt_q <= '0;
            state_q <= WAIT_DONE;
          end
          WAIT_DONE: begin
            tcnt_q <= tcnt_d;
            if (to_hit) begin
              err_q <= 2'd2;
              state_q <= IDLE;
            end else if (ss == 3'b000) begin
              cnt_q <= '0;
              ph_q <= 2'd0;
              cap_data_q <= awg_read_channel_i;
              cap_valid_q <= 1'b1;
              cap_last_q <= ns_q == 32'd1;
              state_q <= READ;
            end
          end
          READ: if (ph_q == 2'd0) begin
            if (cap_valid_q && cap_ready_i) begin
              cap_valid_q <= 1'b0;
              cap_last_q <= 1'b0;
              cnt_q <= cnt_q + 32'd1;
              if (last_rd) begin
                loop_q <= loop_q + 16'd1;
                done_q <= last_loop;
                state_q <= last_loop ? IDLE : WAIT_IDLE_PRE;
              end else begin
                rds_q <= 1'b1;
                ph_q <= 2'd1;
              end
            end
          end else if (ph_q == 2'd1) ph_q <= 2'd2;
          else begin
            cap_data_q <= awg_read_channel_i;
            cap_valid_q <= 1'b1;
            cap_last_q <= last_rd;
            ph_q <= 2'd0;
          end
          DRAIN: begin
            tcnt_q <= tcnt_d;
            if (to_hit || ss == 3'b000) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_awg_sequencer.sv
// tb_awg_sequencer: table-driven runs plus corner sequences against a loopback APG model and capture scoreboard
module tb_awg_sequencer;
  localparam int NSAMP = 128;
  logic axi_clk = 1'b0, axi_resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] num_samples = '0, timeout_cycles = '0;
  logic [15:0] num_loops = '0;
  logic pat_valid = 1'b0, pat_ready, cap_valid, cap_ready = 1'b0, cap_last;
  logic [7:0] pat_data = '0, cap_data, wch, rch;
  logic busy, done, awg_run, wr_strobe, rd_strobe;
  logic [1:0] err_code;
  logic [15:0] loop_idx;
  logic [2:0] status;
  logic [31:0] wr_len;

  awg_sequencer #(.NUM_SIG(8), .NUM_SAMP(NSAMP), .SYNC_STAGES(2)) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .start_i(start), .abort_i(abort),
    .num_samples_i(num_samples), .num_loops_i(num_loops), .timeout_cycles_i(timeout_cycles),
    .pat_valid_i(pat_valid), .pat_ready_o(pat_ready), .pat_data_i(pat_data),
    .cap_valid_o(cap_valid), .cap_ready_i(cap_ready), .cap_data_o(cap_data), .cap_last_o(cap_last),
    .busy_o(busy), .done_o(done), .err_code_o(err_code), .loop_idx_o(loop_idx),
    .awg_run_o(awg_run), .awg_write_channel_o(wch), .awg_wr_strobe_o(wr_strobe),
    .awg_rd_strobe_o(rd_strobe), .awg_read_channel_i(rch), .awg_status_i(status),
    .awg_write_buffer_len_i(wr_len));

  always #5 axi_clk = ~axi_clk;

  // APG model: write buffer looped back to the read side; stall freezes it in RUNNING
  logic [7:0] mem [NSAMP];
  logic [6:0] rd_ptr;
  logic [3:0] dly;
  logic stall = 1'b0;
  assign rch = mem[rd_ptr];
  always @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      status <= 3'b000;
      wr_len <= '0;
      rd_ptr <= '0;
      dly <= '0;
    end else begin
      if (wr_strobe) begin
        mem[wr_len[6:0]] <= wch;
        wr_len <= wr_len + 32'd1;
      end
      if (rd_strobe) rd_ptr <= rd_ptr + 7'd1;
      if (awg_run) begin
        status <= 3'b101;
        dly <= 4'd6;
        rd_ptr <= '0;
      end else if (status == 3'b101 && !stall) begin
        if (dly == 4'd0) status <= 3'b110;
        else dly <= dly - 4'd1;
      end else if (status == 3'b110) begin
        status <= 3'b000;
        wr_len <= '0;
      end
    end

  typedef struct {
    logic [31:0] ns;
    logic [15:0] nl;
    logic [31:0] to;
    bit stall;
    bit rnd;
    logic [1:0] err;
    int dn;
    logic [15:0] li;
    int wr;
    int runs;
    int caps;
    int lat;
  } row_t;
  row_t rows[7];

  logic [7:0] pat_q[$], exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, wr_cnt, run_cnt, done_cnt, cap_cnt, cap_in_loop, cur_ns, run_cyc, zero_streak = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; run_cnt = 0; done_cnt = 0; cap_cnt = 0; cap_in_loop = 0;
    pat_q.delete();
    exp_q.delete();
  endtask

  // one clock: observe pulses, drive the pattern source and capture sink, score handshakes
  task automatic cycle();
    @(negedge axi_clk);
    cyc++;
    if (wr_strobe) wr_cnt++;
    if (awg_run) begin
      run_cnt++;
      run_cyc = cyc;
    end
    if (done) done_cnt++;
    zero_streak = (status == 3'b000) ? zero_streak + 1 : 0;
    pat_valid = pat_q.size() > 0;
    pat_data = pat_valid ? pat_q[0] : 8'h00;
    if (pat_valid && pat_ready) exp_q.push_back(pat_q.pop_front());
    cap_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cap_valid && cap_ready) begin
      chk("cap_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("cap_data", cap_data, exp_q.pop_front());
      chk("cap_last", cap_last, 64'(cap_in_loop == cur_ns - 1));
      cap_in_loop = (cap_in_loop == cur_ns - 1) ? 0 : cap_in_loop + 1;
      cap_cnt++;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy; n++) cycle();
    chk("idle_within_budget", busy, 0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) pat_q.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_row(input row_t r, input int idx);
    int nle, end_cyc;
    clr();
    nle = (r.nl == 0) ? 1 : int'(r.nl);
    cur_ns = int'(r.ns);
    stall = r.stall;
    rnd_ready = r.rnd;
    if (idx == 0) begin
      pat_q.push_back(8'hA5); pat_q.push_back(8'h5A); pat_q.push_back(8'hFF); pat_q.push_back(8'h00);
    end else if (r.ns >= 1 && r.ns <= NSAMP) fill(int'(r.ns) * nle);
    num_samples = r.ns;
    num_loops = r.nl;
    timeout_cycles = r.to;
    pulse_start();
    chk($sformatf("r%0d_busy_after_start", idx), busy, 64'(r.err != 2'd1));
    wait_idle(20000);
    end_cyc = cyc;
    if (r.lat >= 0) chk($sformatf("r%0d_timeout_latency", idx), end_cyc - run_cyc, r.lat);
    cycle();
    cycle();
    chk($sformatf("r%0d_err", idx), err_code, r.err);
    chk($sformatf("r%0d_done", idx), done_cnt, r.dn);
    chk($sformatf("r%0d_loop_idx", idx), loop_idx, r.li);
    chk($sformatf("r%0d_wr_strobes", idx), wr_cnt, r.wr);
    chk($sformatf("r%0d_runs", idx), run_cnt, r.runs);
    chk($sformatf("r%0d_caps", idx), cap_cnt, r.caps);
    chk($sformatf("r%0d_sb_left", idx), exp_q.size(), r.wr - r.caps);
    stall = 1'b0;
    for (int n = 0; n < 100 && status != 3'b000; n++) cycle();
    repeat (4) cycle();
  endtask

  initial begin
    rows = '{
      '{32'd4,   16'd1, 32'd0,    1'b0, 1'b0, 2'd0, 1, 16'd1, 4,   1, 4,   -1},
      '{32'd0,   16'd1, 32'd0,    1'b0, 1'b0, 2'd1, 0, 16'd1, 0,   0, 0,   -1},
      '{32'd129, 16'd1, 32'd0,    1'b0, 1'b0, 2'd1, 0, 16'd1, 0,   0, 0,   -1},
      '{32'd128, 16'd3, 32'd0,    1'b0, 1'b1, 2'd0, 1, 16'd3, 384, 3, 384, -1},
      '{32'd1,   16'd0, 32'd0,    1'b0, 1'b0, 2'd0, 1, 16'd1, 1,   1, 1,   -1},
      '{32'd10,  16'd1, 32'd10,   1'b1, 1'b0, 2'd2, 0, 16'd0, 10,  1, 0,   14},
      '{32'd3,   16'd2, 32'd1000, 1'b0, 1'b1, 2'd0, 1, 16'd2, 6,   2, 6,   -1}
    };
    repeat (3) @(negedge axi_clk);
    chk("reset_outputs", {pat_ready, cap_valid, cap_data, cap_last, busy, done, err_code, loop_idx,
                          awg_run, wch, wr_strobe, rd_strobe}, 0);
    axi_resetn = 1'b1;
    repeat (2) cycle();
    foreach (rows[i]) run_row(rows[i], i);

    // abort in WAIT_DONE holds in DRAIN until the synced status reads idle
    clr();
    cur_ns = 2;
    fill(2);
    stall = 1'b1;
    rnd_ready = 1'b0;
    num_samples = 32'd2; num_loops = 16'd1; timeout_cycles = 32'd0;
    pulse_start();
    for (int n = 0; n < 200 && run_cnt == 0; n++) cycle();
    chk("abort_run_seen", run_cnt, 1);
    repeat (6) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_err", err_code, 3);
    chk("abort_busy_drain", busy, 1);
    repeat (10) cycle();
    chk("drain_hold", busy, 1);
    stall = 1'b0;
    wait_idle(200);
    chk("drain_after_ss0", 64'(zero_streak >= 3), 64'd1);
    chk("abort_err_sticky", err_code, 3);
    chk("abort_no_done", done_cnt, 0);
    clr();
    cur_ns = 2;
    fill(2);
    pulse_start();
    chk("restart_clears_err", err_code, 0);
    wait_idle(2000);
    cycle();
    chk("restart_done", done_cnt, 1);
    chk("restart_caps", cap_cnt, 2);

    // start beats abort in IDLE; a start while busy is ignored
    clr();
    cur_ns = 3;
    fill(3);
    num_samples = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_err", err_code, 0);
    num_samples = 32'd0;
    pulse_start();
    chk("busy_start_ignored", err_code, 0);
    wait_idle(2000);
    cycle();
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_caps", cap_cnt, 3);
    chk("busy_start_err_after", err_code, 0);

    // reset asserted in the middle of LOAD
    clr();
    cur_ns = 8;
    fill(8);
    num_samples = 32'd8;
    pulse_start();
    for (int n = 0; n < 200 && wr_cnt < 3; n++) cycle();
    chk("midload_progress", wr_cnt, 3);
    axi_resetn = 1'b0;
    pat_valid = 1'b0;
    @(negedge axi_clk);
    chk("midload_reset_outputs", {pat_ready, cap_valid, cap_data, cap_last, busy, done, err_code, loop_idx,
                                  awg_run, wch, wr_strobe, rd_strobe}, 0);
    axi_resetn = 1'b1;
    clr();
    repeat (2) cycle();
    chk("post_reset_wr_quiet", wr_cnt, 0);
    run_row(rows[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
